// File: rtl/pacman_pkg.sv
// Shared definitions for the Pac-Man mover: direction encoding, maze geometry
// and FSM state codes.
package pacman_pkg;

  // Direction codes double as indices into the {D,U,R,L} legality vector.
  localparam logic [1:0] DIR_L = 2'b00;
  localparam logic [1:0] DIR_R = 2'b01;
  localparam logic [1:0] DIR_U = 2'b10;
  localparam logic [1:0] DIR_D = 2'b11;

  localparam int SF   = 60;
  localparam int S_X  = 150;
  localparam int S_Y  = 34;
  localparam int COLS = 8;
  localparam int ROWS = 8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_QUERY  = 2'd1;
  localparam state_t ST_DECIDE = 2'd2;
  localparam state_t ST_STEP   = 2'd3;

  // L<->R and U<->D differ only in bit 0.
  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d ^ 2'b01;
  endfunction

endpackage

// File: rtl/pacman_req_latch.sv
// Priority-encodes the direction buttons (L > R > U > D) and holds the pending
// request until it is consumed or replaced; a new press wins over a consume.
module pacman_req_latch
  import pacman_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       consume,
  output logic       req_v,
  output logic [1:0] req_dir
);

  logic       any_btn;
  logic [1:0] enc_dir;

  always_comb begin
    any_btn = btn_l | btn_r | btn_u | btn_d;
    if (btn_l)      enc_dir = DIR_L;
    else if (btn_r) enc_dir = DIR_R;
    else if (btn_u) enc_dir = DIR_U;
    else            enc_dir = DIR_D;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_v   <= 1'b0;
      req_dir <= DIR_R;
    end else if (any_btn) begin
      req_v   <= 1'b1;
      req_dir <= enc_dir;
    end else if (consume) begin
      req_v   <= 1'b0;
    end
  end

endmodule

// File: rtl/pacman_mover.sv
// Pac-Man tile/offset position controller with a legality-query handshake.
// Define PACMAN_WRAP_EN to let horizontal moves wrap across the maze edges.
module pacman_mover
  import pacman_pkg::*;
#(
  parameter int STEP      = 2,
  parameter int START_COL = 0,
  parameter int START_ROW = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_u,
  input  logic       btn_d,
  output logic       q_req,
  output logic [3:0] q_row,
  output logic [3:0] q_col,
  input  logic       q_ack,
  input  logic       leg_l,
  input  logic       leg_r,
  input  logic       leg_u,
  input  logic       leg_d,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic [1:0] dir,
  output logic       moving,
  output logic [1:0] fsm_state
);

`ifdef PACMAN_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  localparam logic [5:0] SF_W    = 6'(SF);
  localparam logic [5:0] STEP_W  = 6'(STEP);
  localparam logic [5:0] OFF_MAX = 6'(SF - STEP);
  localparam logic [3:0] COL_MAX = 4'(COLS - 1);
  localparam logic [3:0] ROW_MAX = 4'(ROWS - 1);

  state_t     state, state_n;
  logic [3:0] col, col_n, row, row_n;
  logic [5:0] off, off_n;
  logic [1:0] dir_n;
  logic       moving_n;
  logic [3:0] leg_q, leg_n, legal_vec;
  logic       consume, req_v, aligned;
  logic [1:0] req_dir;
  logic [9:0] xpos_n, ypos_n;

  pacman_req_latch u_req (
    .clk     (clk),
    .rst     (rst),
    .btn_l   (btn_l),
    .btn_r   (btn_r),
    .btn_u   (btn_u),
    .btn_d   (btn_d),
    .consume (consume),
    .req_v   (req_v),
    .req_dir (req_dir)
  );

  assign aligned   = (off == 6'd0);
  assign q_req     = (state == ST_QUERY);
  assign q_row     = row;
  assign q_col     = col;
  assign fsm_state = state;

  // Grid edges override the maze answer; only columns may wrap.
  always_comb begin
    legal_vec[0] = leg_q[0] & (WRAP | (col != 4'd0));
    legal_vec[1] = leg_q[1] & (WRAP | (col != COL_MAX));
    legal_vec[2] = leg_q[2] & (row != 4'd0);
    legal_vec[3] = leg_q[3] & (row != ROW_MAX);
  end

  always_comb begin
    state_n  = state;
    col_n    = col;
    row_n    = row;
    off_n    = off;
    dir_n    = dir;
    moving_n = moving;
    leg_n    = leg_q;
    consume  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_tick) state_n = aligned ? ST_QUERY : ST_STEP;
      end
      ST_QUERY: begin
        if (q_ack) begin
          leg_n   = {leg_d, leg_u, leg_r, leg_l};
          state_n = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        if (req_v && legal_vec[req_dir]) begin
          dir_n    = req_dir;
          moving_n = 1'b1;
          consume  = 1'b1;
        end else if (!(moving && legal_vec[dir])) begin
          moving_n = 1'b0;
        end
        state_n = ST_STEP;
      end
      default: begin
        // Mid-tile reversal needs no query: the path just travelled is open.
        if (!aligned && req_v && (req_dir == opposite(dir))) begin
          dir_n   = req_dir;
          consume = 1'b1;
        end
        if (moving) begin
          case (dir_n)
            DIR_R: begin
              if (off + STEP_W == SF_W) begin
                col_n = (WRAP && col == COL_MAX) ? 4'd0 : col + 4'd1;
                off_n = 6'd0;
              end else begin
                off_n = off + STEP_W;
              end
            end
            DIR_D: begin
              if (off + STEP_W == SF_W) begin
                row_n = row + 4'd1;
                off_n = 6'd0;
              end else begin
                off_n = off + STEP_W;
              end
            end
            DIR_L: begin
              if (aligned) begin
                col_n = (col == 4'd0) ? COL_MAX : col - 4'd1;
                off_n = OFF_MAX;
              end else begin
                off_n = off - STEP_W;
              end
            end
            default: begin
              if (aligned) begin
                row_n = row - 4'd1;
                off_n = OFF_MAX;
              end else begin
                off_n = off - STEP_W;
              end
            end
          endcase
        end
        state_n = ST_IDLE;
      end
    endcase
  end

  // Pixel position is built from next-state values so it updates with the step.
  always_comb begin
    xpos_n = 10'(S_X) + 10'(col_n) * 10'(SF) + ((dir_n[1] == 1'b0) ? 10'(off_n) : 10'd0);
    ypos_n = 10'(S_Y) + 10'(row_n) * 10'(SF) + ((dir_n[1] == 1'b1) ? 10'(off_n) : 10'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      col    <= 4'(START_COL);
      row    <= 4'(START_ROW);
      off    <= 6'd0;
      dir    <= DIR_R;
      moving <= 1'b0;
      leg_q  <= 4'd0;
      xpos   <= 10'(S_X + START_COL * SF);
      ypos   <= 10'(S_Y + START_ROW * SF);
    end else begin
      state  <= state_n;
      col    <= col_n;
      row    <= row_n;
      off    <= off_n;
      dir    <= dir_n;
      moving <= moving_n;
      leg_q  <= leg_n;
      xpos   <= xpos_n;
      ypos   <= ypos_n;
    end
  end

endmodule

// File: tb/tb_pacman_mover.sv
// Directed bench for pacman_mover: a table of single-frame decisions from reset
// plus hand-written multi-frame sequences (timing, reversal, stop, reset, latch).
module tb_pacman_mover;
  import pacman_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
  logic       q_req;
  logic [3:0] q_row, q_col;
  logic       q_ack = 1'b0;
  logic       leg_l = 1'b0, leg_r = 1'b0, leg_u = 1'b0, leg_d = 1'b0;
  logic [9:0] xpos, ypos;
  logic [1:0] dir;
  logic       moving;
  logic [1:0] fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] last_row, last_col;

  pacman_mover dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
    .q_req(q_req), .q_row(q_row), .q_col(q_col), .q_ack(q_ack),
    .leg_l(leg_l), .leg_r(leg_r), .leg_u(leg_u), .leg_d(leg_d),
    .xpos(xpos), .ypos(ypos), .dir(dir), .moving(moving), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;   // index = direction code: [0]L [1]R [2]U [3]D
    logic [3:0] legs;
    int         exp_dir;
    int         exp_moving;
    int         exp_x;
    int         exp_y;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [3:0] b);
    {btn_d, btn_u, btn_r, btn_l} = b;
  endtask

  task automatic set_legs(input logic [3:0] l);
    {leg_d, leg_u, leg_r, leg_l} = l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame_tick = 1'b0;
    q_ack = 1'b0;
    set_btns(4'b0);
    set_legs(4'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic press(input logic [3:0] b);
    set_btns(b);
    tick();
    set_btns(4'b0);
  endtask

  // One frame: tick, answer any query with legs after ack_delay cycles, and
  // drive dbtn during the DECIDE cycle. Returns whether a query was seen.
  task automatic run_frame(input logic [3:0] legs, input int ack_delay,
                           input logic [3:0] dbtn, output bit queried);
    int guard;
    queried = 1'b0;
    guard = 0;
    while (fsm_state != ST_IDLE && guard < 10) begin
      tick();
      guard++;
    end
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    guard = 0;
    while (fsm_state != ST_IDLE && guard < 40) begin
      if (q_req && !queried) begin
        queried  = 1'b1;
        last_row = q_row;
        last_col = q_col;
        repeat (ack_delay) tick();
        q_ack = 1'b1;
        set_legs(legs);
        tick();
        q_ack = 1'b0;
        set_legs(4'b0);
      end else begin
        if (fsm_state == ST_DECIDE) set_btns(dbtn);
        tick();
        set_btns(4'b0);
      end
      guard++;
    end
    check("frame_done", int'(guard < 40), 1);
  endtask

  task automatic run_frames(input int n, input logic [3:0] legs, output int queries);
    bit q;
    queries = 0;
    for (int i = 0; i < n; i++) begin
      run_frame(legs, 0, 4'b0, q);
      if (q) queries++;
    end
  endtask

  initial begin
    bit q;
    int nq;

    vecs[0] = '{4'b0010, 4'b0010, DIR_R, 1, 152, 34};
    vecs[1] = '{4'b1000, 4'b1000, DIR_D, 1, 150, 36};
    vecs[2] = '{4'b1010, 4'b1111, DIR_R, 1, 152, 34};
    vecs[3] = '{4'b0100, 4'b1111, DIR_R, 0, 150, 34};
`ifdef PACMAN_WRAP_EN
    vecs[4] = '{4'b0001, 4'b1111, DIR_L, 1, 628, 34};
`else
    vecs[4] = '{4'b0001, 4'b1111, DIR_R, 0, 150, 34};
`endif
    vecs[5] = '{4'b0000, 4'b1111, DIR_R, 0, 150, 34};
    vecs[6] = '{4'b1000, 4'b0000, DIR_R, 0, 150, 34};
    vecs[7] = '{4'b1001, 4'b1000, DIR_R, 0, 150, 34};

    // Reset state
    do_reset();
    check("rst_xpos", xpos, 150);
    check("rst_ypos", ypos, 34);
    check("rst_moving", moving, 0);
    check("rst_q_req", q_req, 0);
    check("rst_dir", dir, DIR_R);
    check("rst_state", fsm_state, ST_IDLE);

    // Single aligned-frame decisions from the start tile
    for (int i = 0; i < 8; i++) begin
      do_reset();
      press(vecs[i].btn);
      run_frame(vecs[i].legs, i % 3, 4'b0, q);
      check($sformatf("vec%0d_queried", i), q, 1);
      check($sformatf("vec%0d_qpos", i), {last_row, last_col}, 0);
      check($sformatf("vec%0d_dir", i), dir, vecs[i].exp_dir);
      check($sformatf("vec%0d_moving", i), moving, vecs[i].exp_moving);
      check($sformatf("vec%0d_xpos", i), xpos, vecs[i].exp_x);
      check($sformatf("vec%0d_ypos", i), ypos, vecs[i].exp_y);
    end

    // Aligned-frame cycle timing, held query, ignored late frame_tick
    do_reset();
    press(4'b0010);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    check("t1_q_req", q_req, 1);
    check("t1_q_pos", {q_row, q_col}, 0);
    tick();
    tick();
    check("hold_q_req", q_req, 1);
    check("hold_q_col", q_col, 0);
    q_ack = 1'b1;
    set_legs(4'b0010);
    tick();
    q_ack = 1'b0;
    set_legs(4'b0);
    check("a1_decide", fsm_state, ST_DECIDE);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    check("a2_step", fsm_state, ST_STEP);
    check("a2_xpos_old", xpos, 150);
    tick();
    check("a3_idle", fsm_state, ST_IDLE);
    check("a3_xpos", xpos, 152);
    check("a3_moving", moving, 1);
    tick();
    check("tick_ignored", fsm_state, ST_IDLE);
    run_frames(29, 4'b0010, nq);
    check("run29_queries", nq, 0);
    check("run29_xpos", xpos, 210);
    run_frame(4'b0010, 1, 4'b0, q);
    check("col1_queried", q, 1);
    check("col1_q_col", last_col, 1);
    check("col1_xpos", xpos, 212);

    // Mid-tile reversal at xpos=160
    do_reset();
    press(4'b0010);
    run_frame(4'b0010, 0, 4'b0, q);
    run_frames(4, 4'b0, nq);
    check("rev_pre_xpos", xpos, 160);
    press(4'b0001);
    run_frame(4'b0, 0, 4'b0, q);
    check("rev_no_query", q, 0);
    check("rev_dir", dir, DIR_L);
    check("rev_xpos", xpos, 158);
    check("rev_moving", moving, 1);

    // Blocked at tile (row 1, col 0): stays put
    do_reset();
    press(4'b1000);
    run_frame(4'b1000, 0, 4'b0, q);
    run_frames(29, 4'b0, nq);
    check("down_ypos", ypos, 94);
    run_frame(4'b0000, 0, 4'b0, q);
    check("stop_q_row", last_row, 1);
    check("stop_moving", moving, 0);
    run_frames(5, 4'b0000, nq);
    check("stop_queries", nq, 5);
    check("stop_xpos", xpos, 150);
    check("stop_ypos", ypos, 94);

    // Button during DECIDE is kept for the following aligned frame
    do_reset();
    press(4'b0010);
    run_frame(4'b0010, 0, 4'b0, q);
    run_frames(29, 4'b0, nq);
    run_frame(4'b1111, 0, 4'b1000, q);
    check("late_btn_dir", dir, DIR_R);
    check("late_btn_xpos", xpos, 212);
    run_frames(29, 4'b0, nq);
    run_frame(4'b1111, 0, 4'b0, q);
    check("late_btn_turn", dir, DIR_D);
    check("late_btn_x", xpos, 270);
    check("late_btn_y", ypos, 36);

    // Reset during QUERY, then a stray ack in IDLE
    do_reset();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    check("rq_q_req", q_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rq_dropped", q_req, 0);
    check("rq_state", fsm_state, ST_IDLE);
    q_ack = 1'b1;
    set_legs(4'b1111);
    tick();
    q_ack = 1'b0;
    set_legs(4'b0);
    tick();
    check("stray_ack_state", fsm_state, ST_IDLE);
    check("stray_ack_xpos", xpos, 150);
    check("stray_ack_moving", moving, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
